countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/timer_pkg.sv | 17 +
 rtl/down_counter_ld.sv | 41 ++++
 rtl/countdown_timer.sv | 133 +++++++++++++
 tb/tb_countdown_timer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encodings and a
// small state-decode helper used by the top level.
package timer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t RUN    = 2'd1;
  localparam state_t PAUSED = 2'd2;
  localparam state_t DONE   = 2'd3;

  // Busy covers every state in which a count is in progress, running or frozen.
  function automatic logic state_is_busy(input state_t s);
    return (s == RUN) || (s == PAUSED);
  endfunction

endpackage

// File: rtl/down_counter_ld.sv
// Loadable down counter with enable and zero flag.
// A load always wins over the enable. A decrement at zero is suppressed,
// so the count can never wrap below zero.
module down_counter_ld #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load, else saturating decrement, else hold.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: IDLE/RUN/PAUSED/DONE control FSM around a loadable
// down counter, with optional automatic restart from a stored reload value.
//
// Control handshake: there is no valid/ready pair here. Load, Start and Pause
// are level-sampled commands, each evaluated on every rising edge of Clk.
// Priority is Reset > Load > Pause > Start. A command with no meaning in the
// current state is ignored. Every output is either a register or a decode of
// the state register, so no input reaches an output in the same cycle.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int AUTO_RELOAD = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             Start,
  input  logic             Pause,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             Done,
  output logic             Zero,
  output state_t           DbgState
);

  localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;

  logic             cnt_load;
  logic [WIDTH-1:0] cnt_value;
  logic             cnt_en;
  logic [WIDTH-1:0] cnt_count;
  logic             cnt_zero;
  logic             restart;

  // Automatic restart only makes sense when there is a non-zero value to restart from.
  assign restart = (AUTO_RELOAD != 0) && (reload_q != '0);

  // State register; reset aborts any count without producing a Done pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; Load returns to IDLE from any state.
  always_comb begin
    state_d = state_q;
    if (Load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            state_d = cnt_zero ? DONE : RUN;
          end
        end
        RUN: begin
          if (Pause) begin
            state_d = PAUSED;
          end else if (cnt_count <= CountOne) begin
            // The decrement on this edge reaches zero.
            state_d = DONE;
          end
        end
        PAUSED: begin
          if (Start && !Pause) begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = restart ? RUN : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode from the state register only.
  always_comb begin
    Busy     = state_is_busy(state_q);
    Done     = (state_q == DONE);
    DbgState = state_q;
  end

  // Counter controls: decrement only while running, reload on Load or on restart.
  always_comb begin
    cnt_load  = Load || ((state_q == DONE) && restart);
    cnt_value = Load ? LoadValue : reload_q;
    cnt_en    = (state_q == RUN) && !Pause && !Load;
  end

  // Reload value follows every accepted Load.
  always_comb begin
    reload_d = reload_q;
    if (Load) begin
      reload_d = LoadValue;
    end
  end

  // Reload register with synchronous active-high reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end

  down_counter_ld #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .load_i      (cnt_load),
    .load_value_i(cnt_value),
    .en_i        (cnt_en),
    .count_o     (cnt_count),
    .zero_o      (cnt_zero)
  );

  assign Count = cnt_count;
  assign Zero  = cnt_zero;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one instance without and one with
// automatic reload, sharing the same stimulus.
module tb_countdown_timer;
  import timer_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         load;
  logic [W-1:0] load_value;
  logic         start;
  logic         pause;

  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         zero;
  state_t       st;

  logic [W-1:0] count_ar;
  logic         busy_ar;
  logic         done_ar;
  logic         zero_ar;
  state_t       st_ar;

  int n_checks;
  int n_pass;

  countdown_timer #(.WIDTH(W), .AUTO_RELOAD(0)) dut (
    .Clk      (clk),
    .Reset    (reset),
    .Load     (load),
    .LoadValue(load_value),
    .Start    (start),
    .Pause    (pause),
    .Count    (count),
    .Busy     (busy),
    .Done     (done),
    .Zero     (zero),
    .DbgState (st)
  );

  countdown_timer #(.WIDTH(W), .AUTO_RELOAD(1)) dut_ar (
    .Clk      (clk),
    .Reset    (reset),
    .Load     (load),
    .LoadValue(load_value),
    .Start    (start),
    .Pause    (pause),
    .Count    (count_ar),
    .Busy     (busy_ar),
    .Done     (done_ar),
    .Zero     (zero_ar),
    .DbgState (st_ar)
  );

  // Clock and initial input values.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [W-1:0] lv, input logic s, input logic p);
    load       = ld;
    load_value = lv;
    start      = s;
    pause      = p;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_main(input string tag, input logic [W-1:0] c, input state_t s,
                          input logic b, input logic d, input logic z);
    chk({tag, "_cnt"},  count, c);
    chk({tag, "_st"},   st,    s);
    chk({tag, "_busy"}, busy,  b);
    chk({tag, "_done"}, done,  d);
    chk({tag, "_zero"}, zero,  z);
  endtask

  task automatic chk_ar(input string tag, input logic [W-1:0] c, input state_t s,
                        input logic b, input logic d, input logic z);
    chk({tag, "_cnt"},  count_ar, c);
    chk({tag, "_st"},   st_ar,    s);
    chk({tag, "_busy"}, busy_ar,  b);
    chk({tag, "_done"}, done_ar,  d);
    chk({tag, "_zero"}, zero_ar,  z);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset state.
    do_reset();
    chk_main("rst", 4'd0, IDLE, 1'b0, 1'b0, 1'b1);
    chk_ar("rst_ar", 4'd0, IDLE, 1'b0, 1'b0, 1'b1);

    // Basic run from 5: Done at the fifth edge after Start is sampled.
    drive(1'b1, 4'd5, 1'b0, 1'b0);
    tick();
    chk_main("ld5", 4'd5, IDLE, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    chk_main("start5", 4'd5, RUN, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_main($sformatf("run5_%0d", i), 4'(5 - i), (i == 5) ? DONE : RUN,
               (i < 5), (i == 5), (i == 5));
    end
    tick();
    chk_main("after5", 4'd0, IDLE, 1'b0, 1'b0, 1'b1);
    tick();
    chk_main("idle5", 4'd0, IDLE, 1'b0, 1'b0, 1'b1);

    // Pause after two decrements, hold for three cycles, then resume.
    drive(1'b1, 4'd6, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    chk_main("start6", 4'd6, RUN, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk_main("dec6", 4'd4, RUN, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_main($sformatf("pause_%0d", i), 4'd4, PAUSED, 1'b1, 1'b0, 1'b0);
    end
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    chk_main("resume", 4'd4, RUN, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_main($sformatf("res_%0d", i), 4'(4 - i), (i == 4) ? DONE : RUN,
               (i < 4), (i == 4), (i == 4));
    end
    tick();
    chk_main("after6", 4'd0, IDLE, 1'b0, 1'b0, 1'b1);

    // Load 0 then Start: immediate Done, no underflow.
    drive(1'b1, 4'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    chk_main("zero_start", 4'd0, DONE, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    chk_main("zero_after", 4'd0, IDLE, 1'b0, 1'b0, 1'b1);
    tick();
    chk_main("zero_hold", 4'd0, IDLE, 1'b0, 1'b0, 1'b1);

    // Reset mid-count at 4 aborts with no Done.
    drive(1'b1, 4'd9, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_main($sformatf("run9_%0d", i), 4'(9 - i), RUN, 1'b1, 1'b0, 1'b0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_main("rst_mid", 4'd0, IDLE, 1'b0, 1'b0, 1'b1);
    tick();
    chk_main("rst_mid2", 4'd0, IDLE, 1'b0, 1'b0, 1'b1);

    // Pause+Start together in RUN pauses; Load+Start together goes to IDLE.
    drive(1'b1, 4'd7, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    chk_main("run7", 4'd6, RUN, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 1'b1);
    tick();
    chk_main("ps_both", 4'd6, PAUSED, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 4'd3, 1'b1, 1'b0);
    tick();
    chk_main("ld_start", 4'd3, IDLE, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    chk_main("ld_hold", 4'd3, IDLE, 1'b0, 1'b0, 1'b0);

    // All-ones load takes fifteen decrements.
    drive(1'b1, 4'd15, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    chk_main("start15", 4'd15, RUN, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk_main($sformatf("run15_%0d", i), 4'(15 - i), (i == 15) ? DONE : RUN,
               (i < 15), (i == 15), (i == 15));
    end
    tick();
    chk_main("after15", 4'd0, IDLE, 1'b0, 1'b0, 1'b1);

    // Auto-reload: Done every four cycles, then Load mid-run.
    do_reset();
    drive(1'b1, 4'd3, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    chk_ar("ar_start", 4'd3, RUN, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk_ar($sformatf("ar_%0d", i), 4'(3 - (i % 4)), ((i % 4) == 3) ? DONE : RUN,
             ((i % 4) != 3), ((i % 4) == 3), ((i % 4) == 3));
    end
    drive(1'b1, 4'd2, 1'b0, 1'b0);
    tick();
    chk_ar("ar_ld", 4'd2, IDLE, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    chk_ar("ar_ld_hold", 4'd2, IDLE, 1'b0, 1'b0, 1'b0);

    // Auto-reload with a zero reload value goes back to IDLE.
    drive(1'b1, 4'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    chk_ar("ar0_start", 4'd0, DONE, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    chk_ar("ar0_after", 4'd0, IDLE, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
